lvds_serial_tx: RTL and testbench

Serializing transmitter that drives a pseudo-differential pair toward the iCE40 LVDS input receiver, which samples the line on CLK. Parallel words arrive over a valid/ready handshake. Each word is framed with start and stop bits and shifted out LSB first, with every bit held for a fixed number of CLK cycles so the receiver's oversampler can recover it. The block sits between on-chip data sources and two output pins. It is the transmit end of the link whose receive end is the SB_IO LVDS input plus oversampler.

---
 rtl/lvds_tx_pkg.sv | 35 +++
 rtl/lvds_tx_pad.sv | 30 +++
 rtl/lvds_serial_tx.sv | 182 ++++++++++++++++++
 tb/tb_lvds_serial_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// lvds_tx_pkg: shared types and constants for the LVDS serial transmitter.
// Optional feature macro: LVDS_TX_PARITY_EN adds an even-parity bit per frame.
package lvds_tx_pkg;

`ifdef LVDS_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

  // Line level of the start bit and of the idle/stop condition.
  localparam logic START_LEVEL = 1'b0;
  localparam logic MARK_LEVEL  = 1'b1;

  // Number of line bits in one frame: start + payload (+ parity) + stop.
  function automatic int frame_bits(input int data_w);
`ifdef LVDS_TX_PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction

endpackage

// File: rtl/lvds_tx_pad.sv
// lvds_tx_pad: output register pair for the pseudo-differential line.
// Both legs are registered from the same bit value on the same edge so they
// never skew; on iCE40 these flops pack into the SB_IO registered outputs.
// Reset drives the line to mark (P=1, N=0) immediately.
module lvds_tx_pad (
  input  logic CLK,
  input  logic RESET_N,
  input  logic line_bit,
  output logic TX_P,
  output logic TX_N
);

  logic tx_p_r;
  logic tx_n_r;

  // Register both legs together; reset forces mark without waiting for a clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_p_r <= 1'b1;
      tx_n_r <= 1'b0;
    end else begin
      tx_p_r <= line_bit;
      tx_n_r <= ~line_bit;
    end
  end

  assign TX_P = tx_p_r;
  assign TX_N = tx_n_r;

endmodule

// File: rtl/lvds_serial_tx.sv
// lvds_serial_tx: framed LSB-first serializer with a one-word holding buffer
// in front of the shift register, so a new word can be accepted while the
// previous frame is still on the line. Each line bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: LVDS_TX_PARITY_EN inserts an even-parity bit.
module lvds_serial_tx
  import lvds_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              TX_P,
  output logic              TX_N,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state_r, state_s;
  logic [CNT_W-1:0]  timer_r, timer_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [DATA_W-1:0] hold_r;
  logic              hold_full_r, hold_full_s;
  logic              ready_r, busy_r;
  logic              load_s, accept_s, line_s;
`ifdef LVDS_TX_PARITY_EN
  logic              par_r, par_s;
`endif

  // The holding register only accepts when it was seen empty at the edge.
  assign accept_s    = IN_VALID & ready_r;
  assign hold_full_s = accept_s | (hold_full_r & ~load_s);

  // Next-state logic: bit timer, bit index, shifter and frame sequencing.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    load_s  = 1'b0;
`ifdef LVDS_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          load_s  = 1'b1;
          timer_s = {CNT_W{1'b0}};
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == CNT_LAST) begin
          timer_s = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          state_s = ST_DATA;
        end else begin
          timer_s = timer_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (timer_r == CNT_LAST) begin
          timer_s = {CNT_W{1'b0}};
          shift_s = shift_r >> 1;
          if (idx_r == IDX_LAST) begin
`ifdef LVDS_TX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          timer_s = timer_r + CNT_W'(1);
        end
      end
`ifdef LVDS_TX_PARITY_EN
      ST_PARITY: begin
        if (timer_r == CNT_LAST) begin
          timer_s = {CNT_W{1'b0}};
          state_s = ST_STOP;
        end else begin
          timer_s = timer_r + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (timer_r == CNT_LAST) begin
          timer_s = {CNT_W{1'b0}};
          if (hold_full_r) begin
            // Reload straight into the next start bit: no idle gap.
            load_s  = 1'b1;
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = {CNT_W{1'b0}};
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
    if (load_s) begin
      shift_s = hold_r;
`ifdef LVDS_TX_PARITY_EN
      par_s   = ^hold_r;
`endif
    end else begin
      shift_s = shift_s;
    end
  end

  // Line level for the coming cycle, derived from the next state so the
  // registered pad output lines up with the state it represents.
  always_comb begin
    line_s = MARK_LEVEL;
    case (state_s)
      ST_START:  line_s = START_LEVEL;
      ST_DATA:   line_s = shift_s[0];
`ifdef LVDS_TX_PARITY_EN
      ST_PARITY: line_s = par_s;
`endif
      default:   line_s = MARK_LEVEL;
    endcase
  end

  // State, counters, buffers and handshake/status flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      timer_r     <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      hold_r      <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      hold_r      <= accept_s ? IN_DATA : hold_r;
      hold_full_r <= hold_full_s;
      ready_r     <= ~hold_full_s;
      busy_r      <= (state_s != ST_IDLE) | hold_full_s;
`ifdef LVDS_TX_PARITY_EN
      par_r       <= par_s;
`endif
    end
  end

  assign IN_READY = ready_r;
  assign BUSY     = busy_r;

  lvds_tx_pad u_pad (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .line_bit (line_s),
    .TX_P     (TX_P),
    .TX_N     (TX_N)
  );

endmodule

// File: tb/tb_lvds_serial_tx.sv
// Testbench for lvds_serial_tx: an 8-bit/4-clock instance and a 16-bit/2-clock
// instance, driven from a table of frames plus hand-written reset sequences.
module tb_lvds_serial_tx;
  import lvds_tx_pkg::*;

  logic        CLK;
  logic        RESET_N;
  logic [7:0]  data_a;
  logic        valid_a, rdy_a, txp_a, txn_a, busy_a;
  logic [15:0] data_b;
  logic        valid_b, rdy_b, txp_b, txn_b, busy_b;

  int tests;
  int fails;

  lvds_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(data_a), .IN_VALID(valid_a),
    .IN_READY(rdy_a), .TX_P(txp_a), .TX_N(txn_a), .BUSY(busy_a)
  );

  lvds_serial_tx #(.DATA_W(16), .CLKS_PER_BIT(2)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(data_b), .IN_VALID(valid_b),
    .IN_READY(rdy_b), .TX_P(txp_b), .TX_N(txn_b), .BUSY(busy_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        sel;   // 0: 8-bit/4-clock instance, 1: 16-bit/2-clock
    logic [15:0] w0;
    logic        p0;    // hand-computed even parity of w0
    logic        two;   // second word streamed back-to-back
    logic [15:0] w1;
    logic        p1;
  } vec_t;

  vec_t vecs[5];

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [15:0] d);
    if (sel) begin
      valid_b = v;
      data_b  = d;
    end else begin
      valid_a = v;
      data_a  = d[7:0];
    end
  endtask

  // Expected line level kk cycles after the start bit begins.
  function automatic logic exp_level(input logic [15:0] w, input logic p,
                                     input int dw, input int cpb, input int kk);
    int pos;
    pos = kk / cpb;
    if (pos == 0) return 1'b0;
    if (pos <= dw) return w[pos-1];
    if (frame_bits(dw) == dw + 3 && pos == dw + 1) return p;
    return 1'b1;
  endfunction

  // Present a word and wait (bounded) for the edge that accepts it; returns #1 after it.
  task automatic send_word(input logic sel, input logic [15:0] d, output logic ok);
    ok = 1'b0;
    @(negedge CLK);
    drive(sel, 1'b1, d);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (sel ? rdy_b : rdy_a) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
  endtask

  // Send one frame (or two back-to-back) and check every line cycle.
  task automatic run_frames(input vec_t v, input string name);
    int cpb, dw, flen, nfr, f, kk;
    int e_line, e_n, e_busy, e_rdy, bad_k;
    logic ok, exp, act, bad_act, bad_exp, p, tp, exp_rdy;
    logic [15:0] w;
    cpb = v.sel ? 2 : 4;
    dw  = v.sel ? 16 : 8;
    flen = frame_bits(dw) * cpb;
    nfr  = v.two ? 2 : 1;
    e_line = 0; e_n = 0; e_busy = 0; e_rdy = 0; bad_k = -1;
    bad_act = 1'b0; bad_exp = 1'b0;
    send_word(v.sel, v.w0, ok);
    check1({name, " accept"}, ok, 1'b1);
    if (!ok) begin
      drive(v.sel, 1'b0, v.w0);
      return;
    end
    check1({name, " mark on accept edge"}, v.sel ? txp_b : txp_a, 1'b1);
    check1({name, " ready low on accept"}, v.sel ? rdy_b : rdy_a, 1'b0);
    check1({name, " busy on accept"}, v.sel ? busy_b : busy_a, 1'b1);
    if (v.two) drive(v.sel, 1'b1, v.w1);
    else drive(v.sel, 1'b0, v.w0);
    for (int k = 0; k < nfr * flen; k++) begin
      @(posedge CLK);
      #1;
      if (v.two && k == 1) drive(v.sel, 1'b0, v.w1);
      f  = k / flen;
      kk = k % flen;
      w  = (f != 0) ? v.w1 : v.w0;
      p  = (f != 0) ? v.p1 : v.p0;
      exp = exp_level(w, p, dw, cpb, kk);
      tp  = v.sel ? txp_b : txp_a;
      act = tp;
      if (act !== exp) begin
        if (e_line == 0) begin
          bad_k = k; bad_act = act; bad_exp = exp;
        end
        e_line++;
      end
      if ((v.sel ? txn_b : txn_a) !== ~tp) e_n++;
      if ((v.sel ? busy_b : busy_a) !== 1'b1) e_busy++;
      exp_rdy = !v.two || (k == 0) || (k >= flen);
      if ((v.sel ? rdy_b : rdy_a) !== exp_rdy) e_rdy++;
    end
    tests++;
    if (e_line != 0) begin
      fails++;
      $display("FAIL %s line: %0d bad cycles, first at cycle %0d got %b expected %b",
               name, e_line, bad_k, bad_act, bad_exp);
    end
    tests++;
    if (e_n != 0) begin
      fails++;
      $display("FAIL %s tx_n: %0d cycles where TX_N != ~TX_P, expected 0", name, e_n);
    end
    tests++;
    if (e_busy != 0) begin
      fails++;
      $display("FAIL %s busy: %0d cycles low inside frame, expected 0", name, e_busy);
    end
    tests++;
    if (e_rdy != 0) begin
      fails++;
      $display("FAIL %s ready: %0d cycles wrong, expected 0", name, e_rdy);
    end
    @(posedge CLK);
    #1;
    check1({name, " mark after frame"}, v.sel ? txp_b : txp_a, 1'b1);
    check1({name, " busy falls after frame"}, v.sel ? busy_b : busy_a, 1'b0);
  endtask

  initial begin
    logic ok;
    vec_t tail;
    tests = 0;
    fails = 0;

    //            sel   w0        p0    two   w1        p1
    vecs[0] = '{1'b0, 16'h00A5, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h00FF, 1'b0};
    vecs[3] = '{1'b1, 16'h8001, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'h0080, 1'b1, 1'b1, 16'h0055, 1'b0};

    // Reset held with a word offered: line at mark, not ready.
    RESET_N = 1'b0;
    valid_a = 1'b1;
    data_a  = 8'h77;
    valid_b = 1'b0;
    data_b  = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check1("reset tx_p", txp_a, 1'b1);
    check1("reset tx_n", txn_a, 1'b0);
    check1("reset ready", rdy_a, 1'b0);
    check1("reset busy", busy_a, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check1("ready after release", rdy_a, 1'b1);
    check1("no transfer on release edge", busy_a, 1'b0);
    valid_a = 1'b0;
    @(posedge CLK);
    #1;
    check1("still idle after release", busy_a, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_frames(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a data bit of 0x3C: line to mark at once.
    send_word(1'b0, 16'h003C, ok);
    check1("midreset accept", ok, 1'b1);
    valid_a = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check1("midreset data bit0 low", txp_a, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check1("midreset tx_p mark", txp_a, 1'b1);
    check1("midreset tx_n", txn_a, 1'b0);
    check1("midreset busy", busy_a, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check1("midreset ready after release", rdy_a, 1'b1);
    tail = '{1'b0, 16'h0081, 1'b0, 1'b0, 16'h0000, 1'b0};
    run_frames(tail, "after reset 0x81");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
